// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Handles MULT/MULTU (shift-add), DIV/DIVU (restoring) and MTHI/MTLO, one operation per WIDTH+2 cycles.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wq_q, wq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum, addend, shl, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        abs_a  = (~op[0] & a[WIDTH-1]) ? -a : a;
        abs_b  = (~op[0] & b[WIDTH-1]) ? -b : b;
        // Multiply: {acc,wq} is the product register, multiplier shifts out of wq.
        sum    = {1'b0, acc_q} + {1'b0, opnd_q};
        addend = wq_q[0] ? sum : {1'b0, acc_q};
        // Divide: acc is the partial remainder, quotient bits shift into wq.
        shl    = {acc_q, wq_q[WIDTH-1]};
        diff   = shl - {1'b0, opnd_q};
        prod   = {acc_q, wq_q};

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        wq_d     = wq_q;
        opnd_d   = opnd_q;
        a_orig_d = a_orig_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (we_hi) hi_d = wdata;
                if (we_lo) lo_d = wdata;
                if (start) begin
                    is_div_d = op[1];
                    neg_a_d  = ~op[0] & a[WIDTH-1];
                    neg_b_d  = ~op[0] & b[WIDTH-1];
                    opnd_d   = op[1] ? abs_b : abs_a;
                    wq_d     = op[1] ? abs_a : abs_b;
                    acc_d    = '0;
                    a_orig_d = a;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        wq_d  = {wq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shl[WIDTH-1:0];
                        wq_d  = {wq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = addend[WIDTH:1];
                    wq_d  = {addend[0], wq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    if (opnd_q == '0) begin
                        hi_d = a_orig_q;
                        lo_d = '1;
                    end else begin
                        lo_d = (neg_a_q ^ neg_b_q) ? -wq_q : wq_q;
                        hi_d = neg_a_q ? -acc_q : acc_q;
                    end
                end else begin
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? -prod : prod;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            wq_q     <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            wq_q     <= wq_d;
            opnd_q   <= opnd_d;
            a_orig_q <= a_orig_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo: scoreboard of expected HI/LO per operation,
// plus reset, MTHI/MTLO, ignored restart and mid-operation abort scenarios.
module tb_muldiv_hilo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        we_hi = 1'b0, we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference results from native 64-bit arithmetic: {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sa, sb2, q, r;
        logic [63:0] p;
        sa  = longint'($signed(x));
        sb2 = longint'($signed(y));
        if (!o[1]) begin
            if (o[0]) p = {32'b0, x} * {32'b0, y};
            else      p = sa * sb2;
        end else if (y == 32'd0) begin
            p = {x, 32'hFFFF_FFFF};
        end else if (o[0]) begin
            p = {x % y, x / y};
        end else begin
            q = sa / sb2;
            r = sa % sb2;
            p = {r[31:0], q[31:0]};
        end
        return p;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int restart_at, input int mtlo_at);
        exp_t        e;
        logic [63:0] m;
        logic [31:0] lo0;
        int          k;
        bit          seen, busy_ok;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        m = model(o, x, y);
        e.tag = tag; e.hi = m[63:32]; e.lo = m[31:0];
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        lo0 = lo;
        check({tag, " busy@E0"}, 64'(busy), 64'(1));
        busy_ok = 1'b1;
        seen = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            busy_ok = busy_ok & (busy === 1'b1);
            if (k == restart_at - 1) start = 1'b1;
            if (k == restart_at) start = 1'b0;
            if (mtlo_at > 0) begin
                if (k == mtlo_at) begin we_lo = 1'b1; wdata = 32'hDEAD_BEEF; end
                if (k == mtlo_at + 1) begin
                    we_lo = 1'b0;
                    check({tag, " mtlo_busy"}, 64'(lo), 64'(lo0));
                end
            end
        end
        check({tag, " latency"}, 64'(k), 64'(33));
        check({tag, " busy_held"}, 64'(busy_ok), 64'(1));
        e = sb.pop_front();
        if (seen) begin
            check({e.tag, " hi"}, 64'(hi), 64'(e.hi));
            check({e.tag, " lo"}, 64'(lo), 64'(e.lo));
            check({e.tag, " busy_end"}, 64'(busy), 64'(0));
        end
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int seen_done;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy_done", {62'b0, busy, done}, 64'(0));

        // Both write enables, then an asynchronous mid-cycle reset.
        @(negedge clk); we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h5A5A_0001;
        @(posedge clk); #1; we_hi = 1'b0; we_lo = 1'b0;
        check("mthilo_hi", 64'(hi), 64'(32'h5A5A_0001));
        check("mthilo_lo", 64'(lo), 64'(32'h5A5A_0001));
        #2 reset = 1'b1;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'(0));
        check("async_rst_busy_done", {62'b0, busy, done}, 64'(0));
        @(negedge clk) reset = 1'b0;

        @(negedge clk); we_hi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1; we_hi = 1'b0;
        check("mthi_hi", 64'(hi), 64'(32'h1234));
        check("mthi_lo_kept", 64'(lo), 64'(0));

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max_spec", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
        check("mult_neg_spec", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg_spec", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu", 2'b11, 32'd100, 32'd7, 0, 0);
        check("divu_spec", {hi, lo}, {32'd2, 32'd14});
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 0, 0);
        run_op("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0);
        check("div_ovf_spec", {hi, lo}, {32'd0, 32'h8000_0000});
        run_op("div_both_neg", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 0);
        run_op("multu_mtlo", 2'b01, 32'h0001_0003, 32'h0002_0005, 0, 5);
        for (int i = 0; i < 4; i++)
            run_op($sformatf("rand%0d", i), 2'(i), $urandom, $urandom | 32'd1, 0, 0);

        // Reset asserted mid-operation, just before E15 of a MULTU.
        @(negedge clk); op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'(0));
        check("abort_busy_done", {62'b0, busy, done}, 64'(0));
        @(negedge clk) reset = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'(0));

        run_op("post_abort", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
